// File: rtl/port_sched5_if.sv
// port_sched5_if -- request/grant/credit bundle for the 5-port scheduler.
//   req, tail    : per-input-port flit valid and tail flag (bit i = port i)
//   credit_ret   : downstream FIFO returns one slot this cycle
//   gnt          : registered one-hot grant, 0 when idle
//   out_valid    : a flit transfers this cycle
//   out_sel      : binary index of the granted port (0 when gnt = 0)
//   credit_cnt   : downstream credits currently available
//   credit_err   : sticky credit-overflow flag
//   timeout      : one-cycle pulse on a forced lock release
// Modports: slave = scheduler, master = requester/testbench side.
interface port_sched5_if;
  logic [4:0] req;
  logic [4:0] tail;
  logic       credit_ret;
  logic [4:0] gnt;
  logic       out_valid;
  logic [2:0] out_sel;
  logic [3:0] credit_cnt;
  logic       credit_err;
  logic       timeout;

  modport slave (
    input  req, tail, credit_ret,
    output gnt, out_valid, out_sel, credit_cnt, credit_err, timeout
  );

  modport master (
    output req, tail, credit_ret,
    input  gnt, out_valid, out_sel, credit_cnt, credit_err, timeout
  );
endinterface

// File: rtl/port_sched5.sv
// port_sched5 -- 5-input packet scheduler with least-recently-granted
// arbitration, per-packet locking and downstream credit flow control.
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : port_sched5_if.slave (req/tail/credit_ret in,
//            gnt/out_valid/out_sel/credit_cnt/credit_err/timeout out)
// Parameters: CREDITS (1..15) downstream FIFO depth, TIMEOUT (2..255)
// maximum lock length when the lock timeout is built in.
// Optional feature: define PORT_SCHED5_TIMEOUT_EN to add the 8-bit lock
// counter and forced release; otherwise timeout is tied low and a lock
// is held until the tail flit transfers.
module port_sched5 #(
  parameter int CREDITS = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  port_sched5_if.slave bus
);

  if (CREDITS < 1 || CREDITS > 15) begin : g_bad_credits
    $error("port_sched5: CREDITS out of range 1..15");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("port_sched5: TIMEOUT out of range 2..255");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [4:0] gnt_q, gnt_d;
  // One bit per unordered port pair (i<j): 1 = port i beats port j.
  logic [9:0] pri_q, pri_d;
  logic [3:0] credit_q, credit_d;
  logic       err_q, err_d;
  logic       credit_nz, ov, tail_hit, timeout_w;
  logic [4:0] win;

  function automatic logic [3:0] pidx(input int i, input int j);
    return 4'((i * (9 - i)) / 2 + (j - i - 1));
  endfunction

  function automatic logic beats(input logic [9:0] p, input int i, input int j);
    if (i < j) return p[pidx(i, j)];
    else       return !p[pidx(j, i)];
  endfunction

  // A requester wins only if it beats every other active requester.
  function automatic logic [4:0] lrg_winner(input logic [9:0] p, input logic [4:0] r);
    logic [4:0] w;
    w = '0;
    for (int i = 0; i < 5; i++) begin
      w[i] = r[i];
      for (int j = 0; j < 5; j++)
        if (j != i && r[j] && !beats(p, i, j)) w[i] = 1'b0;
    end
    return w;
  endfunction

  // Make port w lose to every other port; other pairs keep their order.
  function automatic logic [9:0] demote(input logic [9:0] p, input logic [4:0] w1h);
    logic [9:0] n;
    n = p;
    for (int w = 0; w < 5; w++)
      if (w1h[w])
        for (int j = 0; j < 5; j++) begin
          if (j > w) n[pidx(w, j)] = 1'b0;
          if (j < w) n[pidx(j, w)] = 1'b1;
        end
    return n;
  endfunction

  function automatic logic [2:0] enc5(input logic [4:0] g);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 5; i++)
      if (g[i]) s = 3'(i);
    return s;
  endfunction

  assign credit_nz = (credit_q != 4'd0);
  assign ov        = (|(gnt_q & bus.req)) & credit_nz;
  // gnt is one-hot, so masking tail with it picks tail[out_sel].
  assign tail_hit  = |(gnt_q & bus.tail);
  assign win       = lrg_winner(pri_q, bus.req);

`ifdef PORT_SCHED5_TIMEOUT_EN
  logic [7:0] lock_cnt_q, lock_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    pri_d     = pri_q;
    timeout_w = 1'b0;
`ifdef PORT_SCHED5_TIMEOUT_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if ((|bus.req) && credit_nz) begin
          state_d = LOCKED;
          gnt_d   = win;
          pri_d   = demote(pri_q, win);
`ifdef PORT_SCHED5_TIMEOUT_EN
          lock_cnt_d = 8'd0;
`endif
        end
      end
      LOCKED: begin
        if (ov && tail_hit) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
`ifdef PORT_SCHED5_TIMEOUT_EN
        else if (lock_cnt_q == 8'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          timeout_w = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (ov && !bus.credit_ret) begin
      credit_d = credit_q - 4'd1;
    end else if (bus.credit_ret && !ov) begin
      // Return beyond the FIFO depth: saturate and flag.
      if (credit_q == 4'(CREDITS)) err_d = 1'b1;
      else                         credit_d = credit_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      pri_q    <= '0;
      credit_q <= 4'(CREDITS);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      pri_q    <= pri_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

`ifdef PORT_SCHED5_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_cnt_q <= 8'd0;
    else        lock_cnt_q <= lock_cnt_d;
  end
`endif

  assign bus.gnt        = gnt_q;
  assign bus.out_valid  = ov;
  assign bus.out_sel    = enc5(gnt_q);
  assign bus.credit_cnt = credit_q;
  assign bus.credit_err = err_q;
  assign bus.timeout    = timeout_w;

endmodule

// File: tb/tb_port_sched5.sv
module tb_port_sched5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  port_sched5_if bus();

  port_sched5 #(.CREDITS(4), .TIMEOUT(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0; bus.tail = '0; bus.credit_ret = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = 5'b11111; bus.tail = 5'b11111; bus.credit_ret = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    nvec++; if (bus.gnt !== 5'b0) begin nerr++; $display("FAIL reset_gnt got %b want 00000", bus.gnt); end
    nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_ov got %b want 0", bus.out_valid); end
    nvec++; if (bus.out_sel !== 3'd0) begin nerr++; $display("FAIL reset_sel got %0d want 0", bus.out_sel); end
    nvec++; if (bus.credit_cnt !== 4'd4) begin nerr++; $display("FAIL reset_credit got %0d want 4", bus.credit_cnt); end
    nvec++; if (bus.credit_err !== 1'b0) begin nerr++; $display("FAIL reset_err got %b want 0", bus.credit_err); end
    nvec++; if (bus.timeout !== 1'b0) begin nerr++; $display("FAIL reset_timeout got %b want 0", bus.timeout); end
  endtask

  // All ports request single-flit packets; credit returned on each transfer.
  task automatic test_round_robin();
    logic [2:0] ports [0:5];
    logic [4:0] eg;
    ports = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
    do_reset();
    bus.req = 5'b11111; bus.tail = 5'b11111;
    for (int k = 0; k < 12; k++) begin
      bus.credit_ret = k[0];
      eg = k[0] ? (5'b00001 << ports[k/2]) : 5'b00000;
      #1;
      nvec++; if (bus.gnt !== eg) begin nerr++; $display("FAIL rr_gnt[%0d] got %b want %b", k, bus.gnt, eg); end
      nvec++; if (bus.out_valid !== k[0]) begin nerr++; $display("FAIL rr_ov[%0d] got %b want %b", k, bus.out_valid, k[0]); end
      nvec++; if (bus.out_sel !== (k[0] ? ports[k/2] : 3'd0)) begin nerr++; $display("FAIL rr_sel[%0d] got %0d", k, bus.out_sel); end
      nvec++; if (bus.credit_cnt !== 4'd4) begin nerr++; $display("FAIL rr_credit[%0d] got %0d want 4", k, bus.credit_cnt); end
      tick();
    end
    bus.req = '0; bus.credit_ret = 1'b0;
    #1;
    nvec++; if (bus.credit_err !== 1'b0) begin nerr++; $display("FAIL rr_err got %b want 0", bus.credit_err); end
  endtask

  // Port 2 sends 3 flits while port 0 also requests.
  task automatic test_packet();
    logic [4:0] tl [0:5];
    logic [4:0] eg [0:5];
    logic       eo [0:5];
    logic [3:0] ec [0:5];
    tl = '{5'b0, 5'b0, 5'b0, 5'b00100, 5'b0, 5'b0};
    eg = '{5'b0, 5'b00100, 5'b00100, 5'b00100, 5'b0, 5'b00001};
    eo = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ec = '{4'd4, 4'd4, 4'd3, 4'd2, 4'd1, 4'd1};
    do_reset();
    bus.req = 5'b00101;
    for (int k = 0; k < 6; k++) begin
      bus.tail = tl[k];
      #1;
      nvec++; if (bus.gnt !== eg[k]) begin nerr++; $display("FAIL pkt_gnt[%0d] got %b want %b", k, bus.gnt, eg[k]); end
      nvec++; if (bus.out_valid !== eo[k]) begin nerr++; $display("FAIL pkt_ov[%0d] got %b want %b", k, bus.out_valid, eo[k]); end
      nvec++; if (bus.credit_cnt !== ec[k]) begin nerr++; $display("FAIL pkt_credit[%0d] got %0d want %0d", k, bus.credit_cnt, ec[k]); end
      tick();
    end
    bus.req = '0; bus.tail = '0;
  endtask

  // Lock holds while the owner drops req; other requesters are ignored.
  task automatic test_lock_hold();
    do_reset();
    bus.req = 5'b00010; bus.tail = '0;
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.req = 5'b11101;
      #1;
      nvec++; if (bus.gnt !== 5'b00010) begin nerr++; $display("FAIL hold_gnt[%0d] got %b want 00010", k, bus.gnt); end
      nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL hold_ov[%0d] got %b want 0", k, bus.out_valid); end
      nvec++; if (bus.credit_cnt !== 4'd4) begin nerr++; $display("FAIL hold_credit[%0d] got %0d want 4", k, bus.credit_cnt); end
      tick();
    end
    bus.req = 5'b00010; bus.tail = 5'b00010;
    #1;
    nvec++; if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL hold_tail_ov got %b want 1", bus.out_valid); end
    nvec++; if (bus.out_sel !== 3'd1) begin nerr++; $display("FAIL hold_tail_sel got %0d want 1", bus.out_sel); end
    tick();
    bus.req = '0; bus.tail = '0;
    #1;
    nvec++; if (bus.gnt !== 5'b0) begin nerr++; $display("FAIL hold_release got %b want 00000", bus.gnt); end
  endtask

  // 6-flit packet on port 0 with only 4 credits.
  task automatic test_credit_stall();
    logic       cr [0:10];
    logic [4:0] tl [0:10];
    logic [4:0] eg [0:10];
    logic       eo [0:10];
    logic [3:0] ec [0:10];
    int         pulses;
    cr = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    tl = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b00001, 5'b0};
    eg = '{5'b0, 5'b1, 5'b1, 5'b1, 5'b1, 5'b1, 5'b1, 5'b1, 5'b1, 5'b1, 5'b0};
    eo = '{0, 1, 1, 1, 1, 0, 0, 1, 0, 1, 0};
    ec = '{4'd4, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
    pulses = 0;
    do_reset();
    bus.req = 5'b00001;
    for (int k = 0; k < 11; k++) begin
      bus.credit_ret = cr[k]; bus.tail = tl[k];
      #1;
      if (bus.out_valid === 1'b1) pulses++;
      nvec++; if (bus.gnt !== eg[k]) begin nerr++; $display("FAIL cred_gnt[%0d] got %b want %b", k, bus.gnt, eg[k]); end
      nvec++; if (bus.out_valid !== eo[k]) begin nerr++; $display("FAIL cred_ov[%0d] got %b want %b", k, bus.out_valid, eo[k]); end
      nvec++; if (bus.credit_cnt !== ec[k]) begin nerr++; $display("FAIL cred_cnt[%0d] got %0d want %0d", k, bus.credit_cnt, ec[k]); end
      tick();
    end
    nvec++; if (pulses != 6) begin nerr++; $display("FAIL cred_pulses got %0d want 6", pulses); end
    bus.req = '0; bus.tail = '0; bus.credit_ret = 1'b0;
  endtask

  // Simultaneous transfer+return, then overflow return sets sticky error.
  task automatic test_credit_err();
    logic [4:0] rq [0:10];
    logic [4:0] tl [0:10];
    logic       cr [0:10];
    logic [4:0] eg [0:10];
    logic       eo [0:10];
    logic [3:0] ec [0:10];
    logic       ee [0:10];
    rq = '{5'b1, 5'b1, 5'b1, 5'b1, 5'b1, 5'b0, 5'b0, 5'b0, 5'b0, 5'b1, 5'b1};
    tl = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b1, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
    cr = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    eg = '{5'b0, 5'b1, 5'b1, 5'b1, 5'b1, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b1};
    eo = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    ec = '{4'd4, 4'd4, 4'd3, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4};
    ee = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    do_reset();
    for (int k = 0; k < 11; k++) begin
      bus.req = rq[k]; bus.tail = tl[k]; bus.credit_ret = cr[k];
      #1;
      nvec++; if (bus.gnt !== eg[k]) begin nerr++; $display("FAIL err_gnt[%0d] got %b want %b", k, bus.gnt, eg[k]); end
      nvec++; if (bus.out_valid !== eo[k]) begin nerr++; $display("FAIL err_ov[%0d] got %b want %b", k, bus.out_valid, eo[k]); end
      nvec++; if (bus.credit_cnt !== ec[k]) begin nerr++; $display("FAIL err_cnt[%0d] got %0d want %0d", k, bus.credit_cnt, ec[k]); end
      nvec++; if (bus.credit_err !== ee[k]) begin nerr++; $display("FAIL err_flag[%0d] got %b want %b", k, bus.credit_err, ee[k]); end
      tick();
    end
    bus.req = '0; bus.tail = '0; bus.credit_ret = 1'b0;
  endtask

  // Port 3 holds req without tail.
  task automatic test_timeout();
    logic [4:0] eg;
    logic       et;
    do_reset();
    bus.req = 5'b01000; bus.tail = '0;
`ifdef PORT_SCHED5_TIMEOUT_EN
    for (int k = 0; k < 11; k++) begin
      eg = (k == 0 || k == 9) ? 5'b0 : 5'b01000;
      et = (k == 8);
      #1;
      nvec++; if (bus.gnt !== eg) begin nerr++; $display("FAIL to_gnt[%0d] got %b want %b", k, bus.gnt, eg); end
      nvec++; if (bus.timeout !== et) begin nerr++; $display("FAIL to_pulse[%0d] got %b want %b", k, bus.timeout, et); end
      tick();
    end
`else
    for (int k = 0; k < 21; k++) begin
      eg = (k == 0) ? 5'b0 : 5'b01000;
      et = 1'b0;
      #1;
      nvec++; if (bus.gnt !== eg) begin nerr++; $display("FAIL to_gnt[%0d] got %b want %b", k, bus.gnt, eg); end
      nvec++; if (bus.timeout !== et) begin nerr++; $display("FAIL to_pulse[%0d] got %b want %b", k, bus.timeout, et); end
      tick();
    end
`endif
    bus.req = '0;
  endtask

  // Asynchronous reset in the middle of a port-1 packet.
  task automatic test_async_reset();
    do_reset();
    bus.req = 5'b00010; bus.tail = '0;
    tick();
    tick();
    #1;
    nvec++; if (bus.gnt !== 5'b00010) begin nerr++; $display("FAIL ar_pre_gnt got %b want 00010", bus.gnt); end
    #1 rst_n = 1'b0;
    #1;
    nvec++; if (bus.gnt !== 5'b0) begin nerr++; $display("FAIL ar_gnt got %b want 00000", bus.gnt); end
    nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL ar_ov got %b want 0", bus.out_valid); end
    nvec++; if (bus.out_sel !== 3'd0) begin nerr++; $display("FAIL ar_sel got %0d want 0", bus.out_sel); end
    nvec++; if (bus.credit_cnt !== 4'd4) begin nerr++; $display("FAIL ar_credit got %0d want 4", bus.credit_cnt); end
    nvec++; if (bus.credit_err !== 1'b0) begin nerr++; $display("FAIL ar_err got %b want 0", bus.credit_err); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.req = 5'b00011;
    #1;
    nvec++; if (bus.gnt !== 5'b0) begin nerr++; $display("FAIL ar_idle got %b want 00000", bus.gnt); end
    tick();
    nvec++; if (bus.gnt !== 5'b00010) begin nerr++; $display("FAIL ar_regrant got %b want 00010", bus.gnt); end
    nvec++; if (bus.out_sel !== 3'd1) begin nerr++; $display("FAIL ar_regrant_sel got %0d want 1", bus.out_sel); end
    bus.req = '0;
  endtask

  initial begin
    bus.req = '0; bus.tail = '0; bus.credit_ret = 1'b0;
    test_reset();
    test_round_robin();
    test_packet();
    test_lock_hold();
    test_credit_stall();
    test_credit_err();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
